// File: rtl/ibex_instr_aligner.sv
// ibex_instr_aligner
// Turns a stream of word-aligned 32-bit fetch words into one aligned raw
// instruction per output handshake. A 16-bit stash holds the upper half of
// the last consumed word, so that compressed instructions and 32-bit
// instructions spanning two words can be emitted. The instruction PC is
// tracked internally. Branch targets with PC[1]=1 drop the low half of the
// first fetched word.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   branch_i             redirect: flush the stash, restart at branch_addr_i
//   branch_addr_i        redirect target (bit 0 ignored)
//   fetch_valid_i/ready_o/rdata_i/err_i   fetch word handshake and payload
//   out_valid_o/ready_i  aligned instruction handshake
//   out_instr_o          raw instruction; compressed in [15:0], [31:16]=0
//   out_addr_o           PC of out_instr_o
//   out_err_o            fetch error on any part of the instruction
//   out_err_plus2_o      error only on the upper half (PC+2)
module ibex_instr_aligner #(
  parameter bit ResetAll = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o,
  output logic        out_err_plus2_o
);

  logic [15:0] stash_q, stash_d;
  logic        stash_valid_q, stash_valid_d;
  logic        stash_err_q, stash_err_d;
  logic        skip_lo_q, skip_lo_d;
  logic [31:0] pc_q, pc_d;

  logic        lo_compressed;
  logic        stash_compressed;

  assign lo_compressed    = (fetch_rdata_i[1:0] != 2'b11);
  assign stash_compressed = (stash_q[1:0] != 2'b11);
  assign out_addr_o       = pc_q;

  always_comb begin
    stash_d         = stash_q;
    stash_valid_d   = stash_valid_q;
    stash_err_d     = stash_err_q;
    skip_lo_d       = skip_lo_q;
    pc_d            = pc_q;
    out_valid_o     = 1'b0;
    fetch_ready_o   = 1'b0;
    out_instr_o     = fetch_rdata_i;
    out_err_o       = 1'b0;
    out_err_plus2_o = 1'b0;

    if (branch_i) begin
      // Any word presented now belongs to the old stream: accept and drop it.
      fetch_ready_o = 1'b1;
      stash_valid_d = 1'b0;
      pc_d          = {branch_addr_i[31:1], 1'b0};
      skip_lo_d     = branch_addr_i[1];
    end else if (stash_valid_q) begin
      if (stash_compressed) begin
        // Stashed compressed instruction: emitted without touching the fetch side.
        out_valid_o = 1'b1;
        out_instr_o = {16'h0000, stash_q};
        out_err_o   = stash_err_q;
        if (out_ready_i) begin
          stash_valid_d = 1'b0;
          pc_d          = pc_q + 32'd2;
        end
      end else begin
        // Spanning instruction: low half from the stash, high half from the word.
        out_valid_o     = fetch_valid_i;
        fetch_ready_o   = out_ready_i;
        out_instr_o     = {fetch_rdata_i[15:0], stash_q};
        out_err_o       = stash_err_q | fetch_err_i;
        out_err_plus2_o = ~stash_err_q & fetch_err_i;
        if (fetch_valid_i && out_ready_i) begin
          stash_d     = fetch_rdata_i[31:16];
          stash_err_d = fetch_err_i;
          pc_d        = pc_q + 32'd4;
        end
      end
    end else if (skip_lo_q) begin
      fetch_ready_o = 1'b1;
      if (fetch_valid_i) begin
        stash_d       = fetch_rdata_i[31:16];
        stash_valid_d = 1'b1;
        stash_err_d   = fetch_err_i;
        skip_lo_d     = 1'b0;
      end
    end else begin
      out_valid_o   = fetch_valid_i;
      fetch_ready_o = out_ready_i;
      out_err_o     = fetch_err_i;
      if (lo_compressed) begin
        out_instr_o = {16'h0000, fetch_rdata_i[15:0]};
      end
      if (fetch_valid_i && out_ready_i) begin
        if (lo_compressed) begin
          stash_d       = fetch_rdata_i[31:16];
          stash_valid_d = 1'b1;
          stash_err_d   = fetch_err_i;
          pc_d          = pc_q + 32'd2;
        end else begin
          pc_d          = pc_q + 32'd4;
        end
      end
    end

    if (!rst_ni) begin
      out_valid_o   = 1'b0;
      fetch_ready_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stash_valid_q <= 1'b0;
      stash_err_q   <= 1'b0;
      skip_lo_q     <= 1'b0;
    end else begin
      stash_valid_q <= stash_valid_d;
      stash_err_q   <= stash_err_d;
      skip_lo_q     <= skip_lo_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ResetAll && !rst_ni) begin
      stash_q <= '0;
      pc_q    <= '0;
    end else begin
      stash_q <= stash_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_ibex_instr_aligner.sv
module tb_ibex_instr_aligner;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i;
  logic        fetch_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;
  logic        out_err_plus2_o;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  always #5 clk_i = ~clk_i;

  ibex_instr_aligner #(.ResetAll(1'b0)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .branch_i        (branch_i),
    .branch_addr_i   (branch_addr_i),
    .fetch_valid_i   (fetch_valid_i),
    .fetch_ready_o   (fetch_ready_o),
    .fetch_rdata_i   (fetch_rdata_i),
    .fetch_err_i     (fetch_err_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_instr_o     (out_instr_o),
    .out_addr_o      (out_addr_o),
    .out_err_o       (out_err_o),
    .out_err_plus2_o (out_err_plus2_o)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Checks the full output bundle while the handshake is offered.
  task automatic chk_out(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                         input logic err, input logic plus2);
    chk1 ({tag, ".valid"}, out_valid_o, 1'b1);
    chk32({tag, ".instr"}, out_instr_o, instr);
    chk32({tag, ".addr"},  out_addr_o,  addr);
    chk1 ({tag, ".err"},   out_err_o,   err);
    chk1 ({tag, ".plus2"}, out_err_plus2_o, plus2);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_branch(input logic [31:0] addr);
    branch_i      = 1'b1;
    branch_addr_i = addr;
    fetch_valid_i = 1'b0;
    #1;
    chk1("branch.valid", out_valid_o, 1'b0);
    chk1("branch.ready", fetch_ready_o, 1'b1);
    tick();
    branch_i = 1'b0;
  endtask

  task automatic word(input logic [31:0] w, input logic err);
    fetch_valid_i = 1'b1;
    fetch_rdata_i = w;
    fetch_err_i   = err;
    #1;
  endtask

  initial begin
    rst_ni        = 1'b0;
    branch_i      = 1'b0;
    branch_addr_i = '0;
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h0000_0513;
    fetch_err_i   = 1'b0;
    out_ready_i   = 1'b1;
    #1;
    chk1("rst.valid", out_valid_o, 1'b0);
    chk1("rst.ready", fetch_ready_o, 1'b0);
    tick();
    tick();
    rst_ni        = 1'b1;
    fetch_valid_i = 1'b0;
    #1;
    chk1("post_rst.valid", out_valid_o, 1'b0);
    chk1("post_rst.stash_valid", dut.stash_valid_q, 1'b0);
    chk1("post_rst.plus2", out_err_plus2_o, 1'b0);

    // Aligned 32-bit stream
    do_branch(32'h0000_0100);
    word(32'h0000_0513, 1'b0);
    chk_out("al0", 32'h0000_0513, 32'h0000_0100, 1'b0, 1'b0);
    chk1("al0.ready", fetch_ready_o, 1'b1);
    tick();
    word(32'h0010_0593, 1'b0);
    chk_out("al1", 32'h0010_0593, 32'h0000_0104, 1'b0, 1'b0);
    tick();
    fetch_valid_i = 1'b0;
    #1;
    chk1("al.nostash", out_valid_o, 1'b0);

    // Two compressed instructions in one word
    do_branch(32'h0000_0200);
    word(32'h4501_4581, 1'b0);
    chk_out("c0", 32'h0000_4581, 32'h0000_0200, 1'b0, 1'b0);
    chk1("c0.ready", fetch_ready_o, 1'b1);
    tick();
    fetch_valid_i = 1'b0;
    #1;
    chk_out("c1", 32'h0000_4501, 32'h0000_0202, 1'b0, 1'b0);
    chk1("c1.ready", fetch_ready_o, 1'b0);
    tick();

    // Spanning instruction
    do_branch(32'h0000_0300);
    word(32'h0513_4501, 1'b0);
    chk_out("sp0", 32'h0000_4501, 32'h0000_0300, 1'b0, 1'b0);
    tick();
    word(32'h0000_0000, 1'b0);
    chk_out("sp1", 32'h0000_0513, 32'h0000_0302, 1'b0, 1'b0);
    chk1("sp1.ready", fetch_ready_o, 1'b1);
    tick();
    chk32("sp.stash", {16'h0000, dut.stash_q}, 32'h0000_0000);
    chk1("sp.stash_valid", dut.stash_valid_q, 1'b1);
    // Stash holds compressed 0x0000 at 0x306; hold it under backpressure
    out_ready_i   = 1'b0;
    fetch_valid_i = 1'b0;
    #1;
    chk_out("bp", 32'h0000_0000, 32'h0000_0306, 1'b0, 1'b0);
    chk1("bp.ready", fetch_ready_o, 1'b0);

    // Branch while stash valid and decode stalled; presented word is dropped
    branch_i      = 1'b1;
    branch_addr_i = 32'h0000_0800;
    word(32'hDEAD_BEEF, 1'b0);
    chk1("br_st.valid", out_valid_o, 1'b0);
    chk1("br_st.ready", fetch_ready_o, 1'b1);
    tick();
    branch_i    = 1'b0;
    out_ready_i = 1'b1;
    word(32'h0000_0513, 1'b0);
    chk_out("br_st.next", 32'h0000_0513, 32'h0000_0800, 1'b0, 1'b0);
    tick();

    // Unaligned branch target
    do_branch(32'h0000_0402);
    word(32'h4505_ABCD, 1'b0);
    chk1("ua.valid", out_valid_o, 1'b0);
    chk1("ua.ready", fetch_ready_o, 1'b1);
    tick();
    fetch_valid_i = 1'b0;
    #1;
    chk_out("ua.out", 32'h0000_4505, 32'h0000_0402, 1'b0, 1'b0);
    tick();

    // Error on the second half of a spanning instruction, with backpressure
    do_branch(32'h0000_0500);
    word(32'h0513_4501, 1'b0);
    chk_out("e0", 32'h0000_4501, 32'h0000_0500, 1'b0, 1'b0);
    tick();
    out_ready_i = 1'b0;
    word(32'h0000_1234, 1'b1);
    chk_out("e1", 32'h1234_0513, 32'h0000_0502, 1'b1, 1'b1);
    chk1("e1.ready", fetch_ready_o, 1'b0);
    tick();
    chk_out("e1.hold", 32'h1234_0513, 32'h0000_0502, 1'b1, 1'b1);
    out_ready_i = 1'b1;
    #1;
    chk1("e1.ready1", fetch_ready_o, 1'b1);
    tick();
    fetch_valid_i = 1'b0;
    fetch_err_i   = 1'b0;
    #1;
    // Upper half of the erroneous word (0x0000) is now a whole erroneous instruction
    chk_out("e2", 32'h0000_0000, 32'h0000_0506, 1'b1, 1'b0);

    // Reset mid-operation with the stash valid
    rst_ni = 1'b0;
    #1;
    chk1("mrst.valid", out_valid_o, 1'b0);
    chk1("mrst.ready", fetch_ready_o, 1'b0);
    tick();
    rst_ni = 1'b1;
    #1;
    chk1("mrst.post_valid", out_valid_o, 1'b0);
    chk1("mrst.stash_valid", dut.stash_valid_q, 1'b0);

    // Error on the low half of a compressed instruction
    do_branch(32'h0000_0600);
    word(32'h0001_4581, 1'b1);
    chk_out("elo", 32'h0000_4581, 32'h0000_0600, 1'b1, 1'b0);
    tick();
    fetch_valid_i = 1'b0;
    fetch_err_i   = 1'b0;
    #1;
    chk_out("elo.hi", 32'h0000_0001, 32'h0000_0602, 1'b1, 1'b0);
    tick();

    // PC wrap-around
    do_branch(32'hFFFF_FFFC);
    word(32'h0000_0513, 1'b0);
    chk_out("wr0", 32'h0000_0513, 32'hFFFF_FFFC, 1'b0, 1'b0);
    tick();
    word(32'h0000_0001, 1'b0);
    chk_out("wr1", 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
    tick();
    fetch_valid_i = 1'b0;
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
